// File: rtl/ltsm_sb_pkg.sv
// Shared sideband definitions for the LTSM transmit path: message codes,
// default message width and the transmit-queue state encoding.
package ltsm_sb_pkg;

   localparam int SB_MSG_WIDTH_DEF = 4;

   typedef enum logic [SB_MSG_WIDTH_DEF-1:0] {
      SB_MSG_NONE           = 4'd0,
      PHYRETRAIN_START_REQ  = 4'd1,
      PHYRETRAIN_START_RESP = 4'd2,
      PHYRETRAIN_END_REQ    = 4'd3,
      PHYRETRAIN_END_RESP   = 4'd4
   } sb_msg_e;

   typedef enum logic [1:0] {
      Q_IDLE = 2'd0,
      Q_SEND = 2'd1,
      Q_GAP  = 2'd2
   } sb_q_state_e;

endpackage

// File: rtl/sb_msg_fifo.sv
// Small circular buffer holding {message, info} entries for the sideband
// transmit queue; exposes the head entry and the next-cycle occupancy.
module sb_msg_fifo #(
   parameter int WIDTH = 7,
   parameter int DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wdata,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_head,
   output logic [$clog2(DEPTH):0] o_count_next,
   output logic                   o_full,
   output logic                   o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;
   logic             push_ok;
   logic             pop_ok;

   assign o_full  = (count_q == (AW+1)'(DEPTH));
   assign o_empty = (count_q == '0);
   assign push_ok = i_push && !o_full;
   assign pop_ok  = i_pop && !o_empty;
   assign o_head  = mem_q[rd_ptr_q];
   assign o_count_next = count_d;

   always_comb begin
      count_d = count_q;
      if (i_flush) begin
         count_d = '0;
      end else if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointers are exactly log2(DEPTH) wide so they wrap without extra logic.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (i_flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= i_wdata;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/ltsm_sb_tx_queue.sv
// Sideband transmit queue: buffers LTSM messages, offers them to the serializer
// with a valid/ready handshake plus an inter-message gap, and drives SB_Busy.
module ltsm_sb_tx_queue
   import ltsm_sb_pkg::*;
#(
   parameter int SB_MSG_WIDTH = SB_MSG_WIDTH_DEF,
   parameter int INFO_WIDTH   = 3,
   parameter int DEPTH        = 4,
   parameter int GAP_CYCLES   = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg,
   input  logic [INFO_WIDTH-1:0]   i_tx_msg_info,
   input  logic                    i_tx_msg_valid,
   input  logic                    i_flush,
   output logic                    o_SB_Busy,
   output logic [SB_MSG_WIDTH-1:0] o_sb_msg,
   output logic [INFO_WIDTH-1:0]   o_sb_msg_info,
   output logic                    o_sb_msg_valid,
   input  logic                    i_sb_ready,
   output logic                    o_overflow
);

   localparam int EW = SB_MSG_WIDTH + INFO_WIDTH;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

   sb_q_state_e   state_q;
   logic [GW-1:0] gap_q;
   logic          busy_q;
   logic          busy_d;
   logic          ovf_q;
   logic          ovf_d;
   logic          write_req;
   logic          pop;
   logic          full;
   logic          empty;
   logic [EW-1:0] head;
   logic [CW-1:0] count_next;

   // A strobe carrying message 0 is a no-op; flush swallows any same-cycle write.
   assign write_req = i_tx_msg_valid && (i_encoded_SB_msg != '0) && !i_flush;
   assign pop       = (state_q == Q_SEND) && i_sb_ready && !i_flush;

   sb_msg_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_flush      (i_flush),
      .i_push       (write_req),
      .i_wdata      ({i_encoded_SB_msg, i_tx_msg_info}),
      .i_pop        (pop),
      .o_head       (head),
      .o_count_next (count_next),
      .o_full       (full),
      .o_empty      (empty)
   );

   assign o_sb_msg_valid = (state_q == Q_SEND);
   assign o_sb_msg       = o_sb_msg_valid ? head[EW-1:INFO_WIDTH] : '0;
   assign o_sb_msg_info  = o_sb_msg_valid ? head[INFO_WIDTH-1:0] : '0;
   assign o_SB_Busy      = busy_q;
   assign o_overflow     = ovf_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= Q_IDLE;
         gap_q   <= '0;
      end else if (i_flush) begin
         state_q <= Q_IDLE;
         gap_q   <= '0;
      end else begin
         unique case (state_q)
            Q_IDLE: begin
               if (!empty) begin
                  state_q <= Q_SEND;
               end
            end
            Q_SEND: begin
               if (pop) begin
                  if (GAP_CYCLES > 0) begin
                     state_q <= Q_GAP;
                     gap_q   <= GW'(GAP_CYCLES);
                  end else if (count_next == '0) begin
                     state_q <= Q_IDLE;
                  end
               end
            end
            Q_GAP: begin
               if (gap_q <= GW'(1)) begin
                  gap_q   <= '0;
                  state_q <= empty ? Q_IDLE : Q_SEND;
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            default: state_q <= Q_IDLE;
         endcase
      end
   end

   // Busy rises one entry early so a write issued alongside it still fits.
   always_comb begin
      busy_d = i_flush || (count_next >= CW'(DEPTH - 1));
      ovf_d  = ovf_q;
      if (i_flush) begin
         ovf_d = 1'b0;
      end else if (write_req && full) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         busy_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         ovf_q  <= ovf_d;
      end
   end

endmodule
